// File: rtl/sha1_pkg.sv
// Shared SHA-1 definitions: round/group constants, K and initial H values,
// controller state encoding and small bit helpers.
package sha1_pkg;

   localparam int SHA1_ROUNDS      = 80;
   localparam int SHA1_GROUP_LEN   = 20;
   localparam int SHA1_SCHED_DEPTH = 16;

   localparam logic [31:0] SHA1_K0 = 32'h5a827999;
   localparam logic [31:0] SHA1_K1 = 32'h6ed9eba1;
   localparam logic [31:0] SHA1_K2 = 32'h8f1bbcdc;
   localparam logic [31:0] SHA1_K3 = 32'hca62c1d6;

   localparam logic [31:0] SHA1_H0 = 32'h67452301;
   localparam logic [31:0] SHA1_H1 = 32'hefcdab89;
   localparam logic [31:0] SHA1_H2 = 32'h98badcfe;
   localparam logic [31:0] SHA1_H3 = 32'h10325476;
   localparam logic [31:0] SHA1_H4 = 32'hc3d2e1f0;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FEED = 2'd1,
      RUN  = 2'd2,
      DONE = 2'd3
   } sha1State_t;

   // Rotate a word left by one bit.
   function automatic logic [31:0] rotl1(input logic [31:0] x);
      return {x[30:0], x[31]};
   endfunction

   // Map a round index onto its K/function group.
   function automatic logic [1:0] opSelOf(input logic [6:0] rnd);
      logic [1:0] grp;
      if (rnd < 7'(SHA1_GROUP_LEN)) begin
         grp = 2'd0;
      end else if (rnd < 7'(2 * SHA1_GROUP_LEN)) begin
         grp = 2'd1;
      end else if (rnd < 7'(3 * SHA1_GROUP_LEN)) begin
         grp = 2'd2;
      end else begin
         grp = 2'd3;
      end
      return grp;
   endfunction

endpackage

// File: rtl/sha1_w_sched.sv
// SHA-1 message schedule: 16-entry circular buffer holding the last sixteen
// W words. The expansion taps t-3, t-8, t-14 and t all live at fixed offsets
// from the current slot, so a 4-bit index wraps for free.
module sha1_w_sched
   import sha1_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  roundIdx,
   input  logic [31:0] loadWord,
   input  logic        load,
   input  logic        advance,
   output logic [31:0] w
);

   logic [31:0] buffer [SHA1_SCHED_DEPTH];
   logic [3:0]  tap3;
   logic [3:0]  tap8;
   logic [3:0]  tap14;
   logic [31:0] expandW;

   // Expansion taps and the next schedule word, purely from buffer contents.
   always_comb begin
      tap3    = roundIdx - 4'd3;
      tap8    = roundIdx - 4'd8;
      tap14   = roundIdx - 4'd14;
      expandW = rotl1(buffer[tap3] ^ buffer[tap8] ^ buffer[tap14] ^ buffer[roundIdx]);
   end

   assign w = expandW;

   // Buffer write port: streamed words during load, expanded words afterwards.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < SHA1_SCHED_DEPTH; i++) begin
            buffer[i] <= 32'h0;
         end
      end else if (load) begin
         buffer[roundIdx] <= loadWord;
      end else if (advance) begin
         buffer[roundIdx] <= expandW;
      end
   end

endmodule

// File: rtl/sha1_round_ctrl.sv
// SHA-1 round sequencer: accepts 16 streamed message words, issues one feed
// cycle and 80 next cycles with the schedule word and round group, then
// pulses done. Optional build macro SHA1_CTRL_ABORT_EN adds an abort input
// that returns any non-idle state to IDLE on the next edge.
module sha1_round_ctrl
   import sha1_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
`ifdef SHA1_CTRL_ABORT_EN
   input  logic        abort,
`endif
   input  logic        start,
   input  logic        msg_valid,
   output logic        msg_ready,
   input  logic [31:0] msg_word,
   output logic        feed,
   output logic        next,
   output logic [1:0]  op_sel,
   output logic [31:0] w,
   output logic [6:0]  round,
   output logic        busy,
   output logic        done
);

   localparam logic [6:0] LAST_ROUND = 7'(SHA1_ROUNDS - 1);
   localparam logic [6:0] LOAD_ROUNDS = 7'(SHA1_SCHED_DEPTH);

   sha1State_t  stateReg;
   sha1State_t  stateRaw;
   sha1State_t  stateNext;
   logic [6:0]  roundReg;
   logic [6:0]  roundRaw;
   logic [6:0]  roundNext;
   logic        schedLoad;
   logic        schedAdvance;
   logic [31:0] schedW;
   logic        cancel;

   sha1_w_sched uSched (
      .clk      (clk),
      .reset    (reset),
      .roundIdx (roundReg[3:0]),
      .loadWord (msg_word),
      .load     (schedLoad),
      .advance  (schedAdvance),
      .w        (schedW)
   );

   // Abort request, only meaningful outside IDLE (start wins in IDLE).
   always_comb begin
`ifdef SHA1_CTRL_ABORT_EN
      cancel = abort && (stateReg != IDLE);
`else
      cancel = 1'b0;
`endif
   end

   // Next-state, round counter and per-state datapath controls.
   always_comb begin
      stateRaw     = stateReg;
      roundRaw     = roundReg;
      feed         = 1'b0;
      next         = 1'b0;
      msg_ready    = 1'b0;
      schedLoad    = 1'b0;
      schedAdvance = 1'b0;
      w            = 32'h0;
      case (stateReg)
         IDLE: begin
            if (start) begin
               stateRaw = FEED;
            end else begin
               stateRaw = IDLE;
            end
         end
         FEED: begin
            feed     = 1'b1;
            stateRaw = RUN;
         end
         RUN: begin
            if (roundReg < LOAD_ROUNDS) begin
               // Message words pass straight through while they are loaded.
               msg_ready = 1'b1;
               next      = msg_valid;
               w         = msg_word;
               schedLoad = msg_valid;
               if (msg_valid) begin
                  roundRaw = roundReg + 7'd1;
               end else begin
                  roundRaw = roundReg;
               end
            end else begin
               next         = 1'b1;
               w            = schedW;
               schedAdvance = 1'b1;
               if (roundReg == LAST_ROUND) begin
                  stateRaw = DONE;
                  roundRaw = roundReg;
               end else begin
                  roundRaw = roundReg + 7'd1;
               end
            end
         end
         DONE: begin
            stateRaw = IDLE;
            roundRaw = 7'd0;
         end
         default: begin
            stateRaw = IDLE;
            roundRaw = 7'd0;
         end
      endcase
      stateNext = cancel ? IDLE : stateRaw;
      roundNext = cancel ? 7'd0 : roundRaw;
   end

   // State and round registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stateReg <= IDLE;
         roundReg <= 7'd0;
      end else begin
         stateReg <= stateNext;
         roundReg <= roundNext;
      end
   end

   // Status outputs decoded straight from the registers.
   always_comb begin
      busy   = (stateReg != IDLE);
      done   = (stateReg == DONE);
      round  = roundReg;
      op_sel = opSelOf(roundReg);
   end

endmodule
